// File: rtl/pe_conv_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pe_conv_sequencer_if: sample stream in / result stream out.   Rev 1.0
// ----------------------------------------------------------------------------
interface pe_conv_sequencer_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_last
  );
endinterface
`default_nettype wire

// File: rtl/pe_conv_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pe_conv_sequencer: kernel bank + frame sequencer for a 3-tap conv PE.  Rev 1.0
// ----------------------------------------------------------------------------
module pe_conv_sequencer #(
  parameter int FRAME_LEN = 256,
  parameter int NUM_FILT  = 4,
  parameter int TAPS      = 3,
  parameter int PE_LAT    = 1
) (
  input  wire logic                        clk,
  input  wire logic                        rst,
  input  wire logic                        start_i,
  input  wire logic [$clog2(NUM_FILT)-1:0] filt_sel_i,
  output logic                             busy_o,
  output logic                             done_o,
  input  wire logic                        cfg_we_i,
  input  wire logic [$clog2(NUM_FILT)-1:0] cfg_addr_i,
  input  wire logic [23:0]                 cfg_weight_i,
  input  wire logic [7:0]                  cfg_bias_i,
  output logic                             cfg_err_o,
  output logic                             pe_en_o,
  output logic [7:0]                       pe_i0_o,
  output logic [7:0]                       pe_i1_o,
  output logic [7:0]                       pe_i2_o,
  output logic [23:0]                      pe_weight_o,
  output logic [7:0]                       pe_bias_o,
  input  wire logic [15:0]                 pe_y_i,
  pe_conv_sequencer_if.slave               strm
);

  localparam logic [15:0] PRIME_END = 16'(TAPS - 2);
  localparam logic [15:0] LAST_IN   = 16'(FRAME_LEN - 1);
  localparam logic [15:0] N_OUT     = 16'(FRAME_LEN - TAPS + 1);
  localparam logic [15:0] DRAIN_END = 16'(PE_LAT - 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [23:0] bank_w_q [NUM_FILT];
  logic [7:0]  bank_b_q [NUM_FILT];
  logic [23:0] kw_q;
  logic [7:0]  kb_q;
  logic [15:0] in_cnt_q, drain_cnt_q, out_cnt_q;
  logic        m_valid_q, m_last_q, cfg_err_q;

  logic adv, s_rdy, accept, pe_en, tag_in, start_ok, done, busy, feeding;
  logic [PE_LAT-1:0] tag_shift;

  assign busy    = (state_q != S_IDLE);
  assign feeding = (state_q == S_PRIME) || (state_q == S_RUN);

  always_comb begin
    state_d  = state_q;
    adv      = 1'b0;
    s_rdy    = 1'b0;
    accept   = 1'b0;
    pe_en    = 1'b0;
    tag_in   = 1'b0;
    start_ok = 1'b0;
    done     = 1'b0;
    adv    = (feeding || state_q == S_DRAIN) && (!m_valid_q || strm.m_ready);
    s_rdy  = adv && feeding;
    accept = strm.s_valid && s_rdy;
    pe_en  = accept || (adv && state_q == S_DRAIN);
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          start_ok = 1'b1;
          state_d  = S_PRIME;
        end
      end
      S_PRIME: begin
        if (accept && in_cnt_q == PRIME_END) state_d = S_RUN;
      end
      S_RUN: begin
        tag_in = accept;
        // A single-cycle PE leaves nothing in flight, so DRAIN is skipped.
        if (accept && in_cnt_q == LAST_IN) state_d = (PE_LAT == 1) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (pe_en && drain_cnt_q == DRAIN_END) state_d = S_DONE;
      end
      S_DONE: begin
        if (!m_valid_q) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  generate
    if (PE_LAT == 1) begin : g_tag_one
      assign tag_shift = tag_in;
    end else begin : g_tag_pipe
      logic [PE_LAT-1:0] tag_q;
      assign tag_shift = {tag_q[PE_LAT-2:0], tag_in};
      always_ff @(posedge clk) begin
        if (rst)        tag_q <= '0;
        else if (pe_en) tag_q <= tag_shift;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FILT; i++) begin
        bank_w_q[i] <= '0;
        bank_b_q[i] <= '0;
      end
      kw_q        <= '0;
      kb_q        <= '0;
      cfg_err_q   <= 1'b0;
      in_cnt_q    <= '0;
      drain_cnt_q <= '0;
    end else begin
      cfg_err_q <= cfg_we_i && busy;
      if (cfg_we_i && !busy) begin
        bank_w_q[cfg_addr_i] <= cfg_weight_i;
        bank_b_q[cfg_addr_i] <= cfg_bias_i;
      end
      // The kernel is copied out at start so a same-edge write cannot reach this frame.
      if (start_ok) begin
        kw_q        <= bank_w_q[filt_sel_i];
        kb_q        <= bank_b_q[filt_sel_i];
        in_cnt_q    <= '0;
        drain_cnt_q <= '0;
      end else begin
        if (accept) in_cnt_q <= in_cnt_q + 16'd1;
        if (pe_en && state_q == S_DRAIN) drain_cnt_q <= drain_cnt_q + 16'd1;
      end
    end
  end

  // pe_en is only issued with a free output slot, so a new result never overwrites one.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      out_cnt_q <= '0;
    end else begin
      if (start_ok) out_cnt_q <= '0;
      if (m_valid_q && strm.m_ready) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
      if (pe_en && tag_shift[PE_LAT-1]) begin
        m_valid_q <= 1'b1;
        out_cnt_q <= out_cnt_q + 16'd1;
        m_last_q  <= ((out_cnt_q + 16'd1) == N_OUT);
      end
    end
  end

  // The PE output register only moves on pe_en, which is held off while a result waits.
  assign strm.m_data  = m_valid_q ? pe_y_i : 16'd0;
  assign strm.m_valid = m_valid_q;
  assign strm.m_last  = m_last_q;
  assign strm.s_ready = s_rdy;

  assign busy_o      = busy;
  assign done_o      = done;
  assign cfg_err_o   = cfg_err_q;
  assign pe_en_o     = pe_en;
  assign pe_i0_o     = feeding ? strm.s_data : 8'd0;
  assign pe_i1_o     = feeding ? strm.s_data : 8'd0;
  assign pe_i2_o     = feeding ? strm.s_data : 8'd0;
  assign pe_weight_o = kw_q;
  assign pe_bias_o   = kb_q;

endmodule
`default_nettype wire

// File: doc/pe_conv_sequencer.md
Name: pe_conv_sequencer

Overview:
- Frame-level controller for one 3-tap convolution PE: stores a bank of kernel sets, streams one EEG frame into the PE, and qualifies and forwards its outputs.
- Broadcasts each accepted sample to PE inputs i0/i1/i2. The PE's internal buffers form the sliding window, and its registered threshold stage produces y.
- Gates the PE enable on input availability and output backpressure. Discards window-priming outputs and flags end of frame.

Parameters:
- FRAME_LEN, 256, samples per frame (minimum TAPS).
- NUM_FILT, 4, kernel sets held in the bank (power of 2, minimum 2).
- TAPS, 3, PE window length; fixed for this PE.
- PE_LAT, 1, cycles from a PE en-cycle to the corresponding y update (minimum 1).

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle frame start request (sampled in IDLE only).
- filt_sel, input, log2(NUM_FILT), kernel set for the frame; latched on accepted start.
- busy, output, 1, high from accepted start until DONE exits.
- done, output, 1, one-cycle pulse at frame completion.
- cfg_we, input, 1, kernel bank write strobe.
- cfg_addr, input, log2(NUM_FILT), bank entry to write.
- cfg_weight, input, 24, {w2,w1,w0}.
- cfg_bias, input, 8, bias.
- cfg_err, output, 1, one-cycle pulse when a write is rejected.
- s_data, input, 8, sample stream.
- s_valid, input, 1, sample valid.
- s_ready, output, 1, sample accepted when s_valid && s_ready.
- pe_en, output, 1, PE enable (advances buffers and threshold register).
- pe_i0, output, 8, sample to PE.
- pe_i1, output, 8, sample to PE.
- pe_i2, output, 8, sample to PE.
- pe_weight, output, 24, selected kernel.
- pe_bias, output, 8, selected bias.
- pe_y, input, 16, PE output.
- m_data, output, 16, result.
- m_valid, output, 1, result valid.
- m_ready, input, 1, downstream ready.
- m_last, output, 1, final result of frame, qualified by m_valid.

Behaviour:
- Reset: synchronous on rst=1; all outputs 0 at the next edge.
  - State goes to IDLE; counters cleared; bank entries cleared to 0.
  - Reset mid-frame aborts the frame: no done, no m_last; PE is not enabled until a new start.
- States:
  - IDLE: on start=1, latch filt_sel, clear counters, go to PRIME.
  - PRIME: accept TAPS-1 samples, then go to RUN. Tags are 0, so priming outputs are never presented.
  - RUN: accept the remaining samples, tagged valid. After sample FRAME_LEN is accepted, go to DRAIN.
  - DRAIN: issue PE_LAT-1 en-cycles carrying sample 0 and no tag, then go to DONE. With PE_LAT=1, DRAIN lasts 0 cycles when the tag pipe is empty.
  - DONE: wait until m_valid=0, then pulse done and return to IDLE.
- Handshake:
  - adv = (state is PRIME, RUN or DRAIN) && (!m_valid || m_ready).
  - s_ready = adv && state is PRIME or RUN.
  - pe_en = (s_valid && s_ready) || (adv && state is DRAIN).
  - If s_valid=0 in PRIME/RUN, pe_en=0 and the PE state is frozen.
- PE inputs: pe_i0, pe_i1 and pe_i2 carry s_data combinationally; they are 0 outside PRIME/RUN. pe_weight and pe_bias come from the latched bank entry and stay stable for the whole frame.
- Tag pipe: PE_LAT-deep shift register, shifted only on pe_en cycles.
  - When the tail tag is set after a shift, capture pe_y into m_data and set m_valid.
  - m_last is set when the captured result is number FRAME_LEN-TAPS+1.
  - m_valid is held until m_valid && m_ready; m_data is stable while m_valid=1 && m_ready=0.
- Output count: exactly FRAME_LEN-TAPS+1 results per frame; the output counter is 16 bits.
- Kernel bank: a write happens when cfg_we=1 && !busy, at the next edge.
  - A write while busy is dropped and pulses cfg_err for one cycle.
  - A write at the same edge as an accepted start uses the old contents for that frame.
- Frame boundaries:
  - start while busy is ignored.
  - Back-to-back frames are allowed: start may be asserted the cycle after the done pulse.
  - The PE window is not flushed between frames; PRIME discards stale taps.

Test Plan:
- Kernel and stream: write entry 1 = {3,2,1}, bias 0; FRAME_LEN=4 (bench override); start with filt_sel=1; stream 1,2,3,4 with m_ready=1.
  - Expect exactly 2 results, 14 then 20 (3·x[n]+2·x[n-1]+x[n-2]), m_last with 20, then the done pulse, busy=0.
- Input gaps: same setup, s_valid toggled 1,0,0,1,1,0,1.
  - Expect pe_en=0 on every gap, results still 14/20, no extra m_valid.
- Backpressure: m_ready=0 for 5 cycles when the first result appears.
  - Expect m_data=14 held stable, s_ready=0 and pe_en=0 while stalled; 20 follows after release.
- Rejected write: cfg_we during RUN writing entry 1 = {0,0,0}.
  - Expect a cfg_err pulse and current results unchanged. A second frame gives 14/20 again, proving the bank was untouched; back-to-back start the cycle after done is accepted.
- Reset mid-frame: assert rst after 2 samples of a frame.
  - Expect busy, m_valid, s_ready, pe_en and done all 0 at the next edge, and bank entry 1 reads back as 0 (frame yields bias-only 0s).
- Ignored start: start pulsed during RUN with filt_sel=0.
  - Expect it ignored; filter 1 stays in use for the whole frame.
